dcache_flush_ctrl: RTL
======================

# dcache_flush_ctrl

Hardware write-back controller for the data cache in the memory-access stage. On request it walks every data-cache line, writes each valid line's 32-bit block back to the unified 16-bit-wide RAM as two halfword writes, and clears the line's valid bit. It holds the core stalled while running, so the cache and RAM are coherent before a dump, halt or program reload. It replaces the testbench-only write-back walk.

## Interface
Parameters:
- NUM_LINES, 256, number of cache lines.
- INDEX_W, 8, cache index width (log2 NUM_LINES).
- TAG_W, 22, cache tag width.
- RAM_ADDR_W, 13, RAM halfword address width (8192 halfwords).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- flush_req  in  1  start request, sampled only in IDLE.
- flush_busy  out  1  high in every state except IDLE; drives core stall.
- flush_done  out  1  one-cycle pulse when the walk completes.
- cache_idx  out  INDEX_W  index driven to the cache tag/valid/data read port.
- cache_valid  in  1  valid bit of cache_idx, one-cycle read latency.
- cache_tag  in  TAG_W  tag of cache_idx, one-cycle read latency.
- cache_data  in  32  line data {bram_3,bram_2,bram_1,bram_0}, one-cycle read latency.
- cache_inval  out  1  clear the valid bit at cache_idx this cycle.
- ram_we  out  1  RAM halfword write request.
- ram_addr  out  RAM_ADDR_W  RAM halfword address.
- ram_wdata  out  16  RAM write data.
- ram_ready  in  1  RAM accepts the write in a cycle with ram_we && ram_ready.

## Operation
- The FSM has seven states: IDLE, READ, CHECK, WR_LO, WR_HI, NEXT and DONE.
- IDLE: flush_req=1 sets idx to 0 and moves to READ. flush_req is ignored in every other state.
- READ: cache_idx=idx. Moves to CHECK.
- CHECK: latches cache_valid, cache_tag and cache_data into local registers. Goes to WR_LO if valid, otherwise to NEXT.
- Address rule: byte location = {tag, idx, 2'b00}. Halfword address = location >> 1 = {tag, idx, 1'b0}, truncated to the low RAM_ADDR_W bits.
- WR_LO: ram_we=1, ram_addr=hw_addr, ram_wdata=data[15:0]. Stays in WR_LO until ram_ready=1, then moves to WR_HI.
- WR_HI: ram_we=1, ram_addr=hw_addr+1 (modulo 2^RAM_ADDR_W), ram_wdata=data[31:16]. Same handshake, then moves to NEXT.
- While stalled on ram_ready, ram_we, ram_addr and ram_wdata hold stable.
- NEXT: cache_inval=1 with cache_idx=idx, only if the latched valid bit is 1. If idx==NUM_LINES-1, moves to DONE. Otherwise idx increments and the FSM moves to READ.
- End of walk is detected by compare, never by counter overflow.
- DONE: flush_done=1 and flush_busy=1, then moves to IDLE.
- cache_idx holds idx in every non-IDLE state and is 0 in IDLE.

## Timing
- Reset values: state IDLE, idx 0, flush_busy 0, flush_done 0, cache_idx 0, cache_inval 0, ram_we 0, ram_addr 0, ram_wdata 0, latched registers 0.
- flush_req is sampled at edge E; READ for idx 0 occupies the cycle after E and is counted as cycle 0.
- With ram_ready held at 1:
  - invalid line: 3 cycles (READ, CHECK, NEXT);
  - valid line: 5 cycles (READ, CHECK, WR_LO, WR_HI, NEXT).
- DONE occurs in cycle 3·NUM_LINES + 2·(valid line count). flush_busy falls the cycle after DONE.
- Each cycle with ram_ready=0 in WR_LO or WR_HI adds one cycle.
- Reset mid-operation returns to IDLE on the next edge: no done pulse, and any pending write is abandoned with ram_we=0.
- A flush_req asserted in the DONE cycle is ignored. A flush_req held high in IDLE starts a new walk.

## Test plan
- Reset: all outputs are 0. flush_req held at 0 for 10 cycles leaves flush_busy at 0.
- All lines invalid, flush_req pulsed, plus a second flush_req pulse at cycle 100:
  - ram_we never asserts and cache_inval never asserts;
  - flush_done pulses exactly at cycle 768;
  - the second pulse has no effect.
- Line 0 valid, tag 0, data 0xABFA0CFB; all other lines invalid:
  - writes addr 0x000 data 0x0CFB, then addr 0x001 data 0xABFA;
  - cache_inval with idx 0;
  - done at cycle 770.
- Line 5 valid, tag 1, data 0x123456F0 (location 0x414):
  - writes addr 0x20A data 0x56F0, then addr 0x20B data 0x1234.
- Line 0 valid, ram_ready held at 0 for 3 cycles in WR_LO:
  - ram_we, ram_addr and ram_wdata stay stable for 4 cycles;
  - done is delayed to cycle 773.
- reset asserted while idx=100:
  - next cycle all outputs are 0 and no flush_done pulse occurs;
  - a new flush_req restarts the walk at idx 0 and completes normally.

Source files
------------

// File: rtl/dcache_flush_ctrl.sv
// Data-cache write-back walker: flushes every valid line to the
// 16-bit RAM as two halfwords and invalidates it, stalling the core.
module dcache_flush_ctrl #(
  parameter int NUM_LINES  = 256,
  parameter int INDEX_W    = 8,
  parameter int TAG_W      = 22,
  parameter int RAM_ADDR_W = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic [INDEX_W-1:0]    cache_idx,
  input  logic                  cache_valid,
  input  logic [TAG_W-1:0]      cache_tag,
  input  logic [31:0]           cache_data,
  output logic                  cache_inval,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [15:0]           ram_wdata,
  input  logic                  ram_ready
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WR_LO,
    WR_HI,
    NEXT,
    DONE
  } state_t;

  localparam logic [INDEX_W-1:0] LAST_IDX =
    INDEX_W'(NUM_LINES - 1);
  localparam logic [INDEX_W-1:0] IDX_ONE =
    INDEX_W'(1);
  localparam logic [RAM_ADDR_W-1:0] ADDR_ONE =
    RAM_ADDR_W'(1);

  state_t              state_q, state_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic                valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [31:0]         data_q, data_d;

  logic [TAG_W+INDEX_W:0]  hw_full;
  logic [RAM_ADDR_W-1:0]   hw_addr;
  logic                    unused_hw_bits;

  // Halfword address {tag, idx, 0}; upper bits fall off the RAM.
  assign hw_full = {tag_q, idx_q, 1'b0};
  assign hw_addr = hw_full[RAM_ADDR_W-1:0];
  assign unused_hw_bits =
    ^hw_full[TAG_W+INDEX_W:RAM_ADDR_W];

  // State, walk index and latched line registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  // Next-state and Moore outputs of the walk.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    flush_busy  = (state_q != IDLE);
    flush_done  = 1'b0;
    cache_idx   = (state_q == IDLE) ? '0 : idx_q;
    cache_inval = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          idx_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        state_d = CHECK;
      end
      CHECK: begin
        valid_d = cache_valid;
        tag_d   = cache_tag;
        data_d  = cache_data;
        state_d = cache_valid ? WR_LO : NEXT;
      end
      WR_LO: begin
        ram_we    = 1'b1;
        ram_addr  = hw_addr;
        ram_wdata = data_q[15:0];
        if (ram_ready) state_d = WR_HI;
      end
      WR_HI: begin
        ram_we    = 1'b1;
        ram_addr  = hw_addr + ADDR_ONE;
        ram_wdata = data_q[31:16];
        if (ram_ready) state_d = NEXT;
      end
      NEXT: begin
        cache_inval = valid_q;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = READ;
        end
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
